// File: rtl/tex_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tex_mem_arbiter
//
// Shares a single memory port among NREQ texture-unit requesters. Requests
// are granted round-robin, and only one memory transaction is outstanding at
// a time. A transaction that the memory does not acknowledge within TIMEOUT
// WAIT cycles is still completed towards its requester: the response data is
// zero and err_timeout is raised.
//
// Handshake: req_valid[i] is a level request. The requester holds it, with a
// stable address, until it sees its one-cycle req_ack[i] pulse. rsp_data is
// only meaningful in that req_ack cycle. mem_req is a one-cycle pulse, and
// mem_ack is a one-cycle pulse that is honoured only in ISSUE or WAIT.
//
// Ports
//   clk, rst_n    clock; asynchronous active-low reset
//   req_valid     [NREQ]         per-requester fetch request (level)
//   req_addr      [NREQ*ADDR_W]  per-requester address, slice i*ADDR_W
//   req_ack       [NREQ]         one-hot completion pulse
//   rsp_data      [DATA_W]       response line, broadcast
//   mem_req       1              memory request pulse
//   mem_addr      [ADDR_W]       address of the current transaction
//   mem_ack       1              memory completion pulse
//   mem_data      [DATA_W]       memory line, valid with mem_ack
//   busy          1              FSM not in IDLE
//   owner         [OW]           current or last granted requester
//   err_timeout   1              timeout flag, coincident with req_ack
//   dbg_state     [2]            FSM state (IDLE=0 ISSUE=1 WAIT=2 RESP=3)
// ---------------------------------------------------------------------------
module tex_mem_arbiter #(
    parameter int NREQ    = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 128,
    parameter int TIMEOUT = 255,   // must be >= 1
    localparam int OW     = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW     = $clog2(TIMEOUT + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    output logic [NREQ-1:0]        req_ack,
    output logic [DATA_W-1:0]      rsp_data,
    output logic                   mem_req,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic                   mem_ack,
    input  logic [DATA_W-1:0]      mem_data,
    output logic                   busy,
    output logic [OW-1:0]          owner,
    output logic                   err_timeout,
    output logic [1:0]             dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e              state_q;
    logic [NREQ-1:0]     req_ack_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic                mem_req_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [OW-1:0]       owner_q;
    logic                err_q;
    logic [CW-1:0]       wait_cnt_q;
    logic [OW-1:0]       last_grant_q;

    // Round-robin winner: walk from last_grant+1 upwards with wrap; the
    // first requester found valid wins.
    logic                grant_found;
    logic [OW-1:0]       grant_idx;
    logic [OW-1:0]       cand;
    logic [ADDR_W-1:0]   grant_addr;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = last_grant_q;
        for (int k = 0; k < NREQ; k++) begin
            cand = (cand == OW'(NREQ - 1)) ? '0 : cand + 1'b1;
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
        grant_addr = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            req_ack_q    <= '0;
            rsp_data_q   <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            owner_q      <= '0;
            err_q        <= 1'b0;
            wait_cnt_q   <= '0;
            last_grant_q <= OW'(NREQ - 1);
        end else begin
            // Pulse outputs default low; the branches below raise them for
            // exactly one cycle.
            mem_req_q <= 1'b0;
            req_ack_q <= '0;
            err_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (grant_found) begin
                        owner_q    <= grant_idx;
                        mem_addr_q <= grant_addr;
                        mem_req_q  <= 1'b1;
                        wait_cnt_q <= '0;
                        state_q    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (mem_ack) begin
                        rsp_data_q <= mem_data;
                        req_ack_q  <= NREQ'(1) << owner_q;
                        state_q    <= S_RESP;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // An ack in the last allowed WAIT cycle still wins over
                    // the timeout.
                    if (mem_ack) begin
                        rsp_data_q <= mem_data;
                        req_ack_q  <= NREQ'(1) << owner_q;
                        state_q    <= S_RESP;
                    end else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
                        rsp_data_q <= '0;
                        req_ack_q  <= NREQ'(1) << owner_q;
                        err_q      <= 1'b1;
                        state_q    <= S_RESP;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                S_RESP: begin
                    last_grant_q <= owner_q;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ack     = req_ack_q;
    assign rsp_data    = rsp_data_q;
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign busy        = (state_q != S_IDLE);
    assign owner       = owner_q;
    assign err_timeout = err_q;
    assign dbg_state   = state_q;

endmodule
